pipelined_cla_adder: RTL and testbench

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- Successor to the fixed 16-bit, four-group lookahead carry unit. Generalised to any `WIDTH` that is a multiple of `GROUP`; adds registered carry-out and optional overflow/zero flags.
- Sits between the miniRISC register-read stage and the ALU result mux; any back-pressure from the result mux stalls it.

---
 rtl/cla_pkg.sv | 29 ++
 rtl/cla_group_lcu.sv | 47 ++++
 rtl/pipelined_cla_adder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg -- shared types and helpers for the pipelined carry-lookahead adder.
//
// Contents:
//   CLA_MAX_GROUPS : largest supported lookahead group count (WIDTH/GROUP).
//   CLA_MAX_WIDTH  : widest operand the S1 register struct can carry.
//   grp_count()    : number of lookahead groups for a given WIDTH/GROUP.
//   cla_s1_t       : contents of the S1 pipeline register. Fields are sized
//                    for the widest build; a given instance uses the low
//                    WIDTH (or WIDTH/GROUP) bits and leaves the rest at zero.
package cla_pkg;

    localparam int CLA_MAX_GROUPS = 16;
    localparam int CLA_MAX_WIDTH  = 128;

    function automatic int grp_count(input int width, input int group);
        return width / group;
    endfunction

    typedef struct packed {
        logic [CLA_MAX_WIDTH-1:0]  a;      // operand A
        logic [CLA_MAX_WIDTH-1:0]  b;      // operand B after optional inversion
        logic [CLA_MAX_WIDTH-1:0]  p;      // per-bit propagate a ^ b'
        logic [CLA_MAX_GROUPS-1:0] grp_p;  // per-group propagate
        logic [CLA_MAX_GROUPS-1:0] grp_g;  // per-group generate
        logic                      c0;     // carry into bit 0
        logic                      sub;    // operation was a subtraction
    } cla_s1_t;

endpackage

// File: rtl/cla_group_lcu.sv
// cla_group_lcu -- flattened lookahead carry unit across N groups.
//
// Every group carry is built directly from c0 and the group P/G terms as a
// two-level sum of products, so no carry ripples from one group to the next.
//
// Ports:
//   c0     in  1    : carry into group 0
//   grp_p  in  N    : group propagate terms
//   grp_g  in  N    : group generate terms
//   carry  out N+1  : carry[k] is the carry into group k; carry[N] is the
//                     carry out of the top group
module cla_group_lcu #(
    parameter int N = 8
) (
    input  logic         c0,
    input  logic [N-1:0] grp_p,
    input  logic [N-1:0] grp_g,
    output logic [N:0]   carry
);

    logic term;
    logic acc;

    always_comb begin
        term     = 1'b0;
        acc      = 1'b0;
        carry    = '0;
        carry[0] = c0;
        for (int k = 1; k <= N; k++) begin
            // c0 propagated through every group below k
            acc = c0;
            for (int n = 0; n < k; n++) begin
                acc = acc & grp_p[n];
            end
            // plus each lower group's generate propagated through the groups above it
            for (int m = 0; m < k; m++) begin
                term = grp_g[m];
                for (int n = m + 1; n < k; n++) begin
                    term = term & grp_p[n];
                end
                acc = acc | term;
            end
            carry[k] = acc;
        end
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder -- two-stage carry-lookahead adder/subtractor with
// valid/ready handshake on input and output.
//
// S1 forms b', c0, per-bit propagate and per-group P/G. S2 resolves group
// carries through cla_group_lcu, expands them to bit carries inside each
// group and registers the sum and carry-out. Results appear two cycles after
// accept; a stalled output holds both stages.
//
// Optional feature macro: CLA_FLAGS_EN adds out_ovf and out_zero.
//
// Ports:
//   clk        in   1      : clock, rising edge
//   rst_n      in   1      : asynchronous active-low reset
//   in_valid   in   1      : operands present
//   in_ready   out  1      : operands accepted this cycle
//   in_a       in   WIDTH  : operand A
//   in_b       in   WIDTH  : operand B
//   in_sub     in   1      : 1 = A-B, 0 = A+B+in_cin
//   in_cin     in   1      : carry-in (ignored when in_sub=1)
//   out_valid  out  1      : result valid
//   out_ready  in   1      : consumer accepts result
//   out_sum    out  WIDTH  : sum / difference
//   out_cout   out  1      : carry out of MSB (subtraction: 1 = no borrow)
//   out_ovf    out  1      : signed overflow (CLA_FLAGS_EN only)
//   out_zero   out  1      : out_sum is zero (CLA_FLAGS_EN only)
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CLA_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero
`endif
);

    localparam int NG = grp_count(WIDTH, GROUP);

    if ((WIDTH % GROUP) != 0) begin : g_chk_mult
        $error("WIDTH must be a multiple of GROUP");
    end
    if (NG > CLA_MAX_GROUPS) begin : g_chk_groups
        $error("WIDTH/GROUP exceeds CLA_MAX_GROUPS");
    end
    if (WIDTH > CLA_MAX_WIDTH) begin : g_chk_width
        $error("WIDTH exceeds CLA_MAX_WIDTH");
    end

    // Group generate: OR over bits of g[m] propagated through all higher bits.
    function automatic logic grp_gen(input logic [GROUP-1:0] p,
                                     input logic [GROUP-1:0] g);
        logic res;
        logic t;
        res = 1'b0;
        for (int m = 0; m < GROUP; m++) begin
            t = g[m];
            for (int n = m + 1; n < GROUP; n++) begin
                t = t & p[n];
            end
            res = res | t;
        end
        return res;
    endfunction

    // Carry into each bit of a group, each one a flat sum of products of cin.
    function automatic logic [GROUP-1:0] grp_bit_carries(input logic [GROUP-1:0] p,
                                                         input logic [GROUP-1:0] g,
                                                         input logic             cin);
        logic [GROUP-1:0] c;
        logic             acc;
        logic             t;
        c = '0;
        for (int i = 0; i < GROUP; i++) begin
            acc = cin;
            for (int n = 0; n < i; n++) begin
                acc = acc & p[n];
            end
            for (int m = 0; m < i; m++) begin
                t = g[m];
                for (int n = m + 1; n < i; n++) begin
                    t = t & p[n];
                end
                acc = acc | t;
            end
            c[i] = acc;
        end
        return c;
    endfunction

    // Handshake state
    logic vld_p1_q, vld_p1_d;
    logic vld_p2_q, vld_p2_d;
    logic s2_adv;
    logic accept;

    assign s2_adv   = vld_p1_q & (~vld_p2_q | out_ready);
    assign in_ready = ~vld_p1_q | s2_adv;
    assign accept   = in_valid & in_ready;

    always_comb begin
        vld_p1_d = vld_p1_q;
        if (accept) begin
            vld_p1_d = 1'b1;
        end else if (s2_adv) begin
            vld_p1_d = 1'b0;
        end
        vld_p2_d = vld_p2_q;
        if (s2_adv) begin
            vld_p2_d = 1'b1;
        end else if (out_ready) begin
            vld_p2_d = 1'b0;
        end
    end

    // ---- Stage 1: operand conditioning and group P/G ----
    logic [WIDTH-1:0] b_cond;
    logic [WIDTH-1:0] bit_p;
    logic [WIDTH-1:0] bit_g;
    logic [NG-1:0]    grp_p_new;
    logic [NG-1:0]    grp_g_new;
    cla_s1_t          s1_p1_q, s1_p1_d;

    assign b_cond = in_sub ? ~in_b : in_b;
    assign bit_p  = in_a ^ b_cond;
    assign bit_g  = in_a & b_cond;

    always_comb begin
        grp_p_new = '0;
        grp_g_new = '0;
        for (int k = 0; k < NG; k++) begin
            grp_p_new[k] = &bit_p[k*GROUP +: GROUP];
            grp_g_new[k] = grp_gen(bit_p[k*GROUP +: GROUP], bit_g[k*GROUP +: GROUP]);
        end
    end

    always_comb begin
        s1_p1_d = s1_p1_q;
        if (accept) begin
            s1_p1_d               = '0;
            s1_p1_d.a[WIDTH-1:0]  = in_a;
            s1_p1_d.b[WIDTH-1:0]  = b_cond;
            s1_p1_d.p[WIDTH-1:0]  = bit_p;
            s1_p1_d.grp_p[NG-1:0] = grp_p_new;
            s1_p1_d.grp_g[NG-1:0] = grp_g_new;
            s1_p1_d.c0            = in_sub | in_cin;
            s1_p1_d.sub           = in_sub;
        end
    end

    // ---- Stage 2: group carries, bit carries, sum ----
    logic [WIDTH-1:0] s2_p;
    logic [WIDTH-1:0] s2_g;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] bit_c;
    logic [WIDTH-1:0] sum_new;

    // Bit generates are recomputed from the registered operands rather than
    // carried through S1 as another WIDTH-bit field.
    assign s2_p = s1_p1_q.p[WIDTH-1:0];
    assign s2_g = s1_p1_q.a[WIDTH-1:0] & s1_p1_q.b[WIDTH-1:0];

    cla_group_lcu #(
        .N (NG)
    ) u_lcu (
        .c0    (s1_p1_q.c0),
        .grp_p (s1_p1_q.grp_p[NG-1:0]),
        .grp_g (s1_p1_q.grp_g[NG-1:0]),
        .carry (grp_c)
    );

    always_comb begin
        bit_c = '0;
        for (int k = 0; k < NG; k++) begin
            bit_c[k*GROUP +: GROUP] = grp_bit_carries(s2_p[k*GROUP +: GROUP],
                                                      s2_g[k*GROUP +: GROUP],
                                                      grp_c[k]);
        end
    end

    assign sum_new = s2_p ^ bit_c;

    logic [WIDTH-1:0] sum_p2_q, sum_p2_d;
    logic             cout_p2_q, cout_p2_d;

    always_comb begin
        sum_p2_d  = sum_p2_q;
        cout_p2_d = cout_p2_q;
        if (s2_adv) begin
            sum_p2_d  = sum_new;
            cout_p2_d = grp_c[NG];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            s1_p1_q   <= '0;
            sum_p2_q  <= '0;
            cout_p2_q <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            s1_p1_q   <= s1_p1_d;
            sum_p2_q  <= sum_p2_d;
            cout_p2_q <= cout_p2_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign out_sum   = sum_p2_q;
    assign out_cout  = cout_p2_q;

`ifdef CLA_FLAGS_EN
    // ---- Stage 2 flags: MSB carry-in and zero reduction ----
    logic msb_cin_p2_q, msb_cin_p2_d;
    logic zero_p2_q, zero_p2_d;

    always_comb begin
        msb_cin_p2_d = msb_cin_p2_q;
        zero_p2_d    = zero_p2_q;
        if (s2_adv) begin
            msb_cin_p2_d = bit_c[WIDTH-1];
            zero_p2_d    = ~|sum_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_cin_p2_q <= 1'b0;
            zero_p2_q    <= 1'b0;
        end else begin
            msb_cin_p2_q <= msb_cin_p2_d;
            zero_p2_q    <= zero_p2_d;
        end
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign out_ovf  = msb_cin_p2_q ^ cout_p2_q;
    assign out_zero = zero_p2_q;
`endif

    // The sub flag and the struct bits above WIDTH/NG carry no logic in S2.
    logic unused_s1;
    assign unused_s1 = ^{s1_p1_q};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
`ifdef CLA_FLAGS_EN
    logic        out_ovf;
    logic        out_zero;
`endif

    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .WIDTH (32),
        .GROUP (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef CLA_FLAGS_EN
        ,
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    // Hand-computed vectors: a, b, sub, cin, sum, cout, ovf
    localparam int NV = 12;
    vec_t vecs [NV] = '{
        '{32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0},
        '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
        '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0},
        '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0},
        '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0},
        '{32'h0000_0010, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1},
        '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0},
        '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0},
        '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1}
    };

    // Back-to-back adds: a, b, sum, cout
    logic [31:0] bb_a    [4] = '{32'h0000_0001, 32'h0000_0010, 32'hFFFF_FFFF, 32'h00FF_00FF};
    logic [31:0] bb_b    [4] = '{32'h0000_0002, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0F0F_0F0F};
    logic [31:0] bb_sum  [4] = '{32'h0000_0003, 32'h0000_0030, 32'hFFFF_FFFE, 32'h100E_100E};
    logic        bb_cout [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_sub    = v.sub;
        in_cin    = v.cin;
        out_ready = 1'b1;
        chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d_valid_c1", idx), out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_valid_c2", idx), out_valid, 1);
        chk($sformatf("v%0d_sum", idx), out_sum, v.sum);
        chk($sformatf("v%0d_cout", idx), out_cout, v.cout);
`ifdef CLA_FLAGS_EN
        chk($sformatf("v%0d_ovf", idx), out_ovf, v.ovf);
        chk($sformatf("v%0d_zero", idx), out_zero, (v.sum == 32'h0));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit m_v1, m_v2, ordy, exp_rdy, adv, acc, saw_low;
        int sent, rcv;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef CLA_FLAGS_EN
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_out_zero", out_zero, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Directed single operations
        for (int i = 0; i < NV; i++) begin
            run_vec(i);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("drain_valid", out_valid, 0);

        // Back-to-back with stall in cycles 3..5
        m_v1 = 0; m_v2 = 0; sent = 0; rcv = 0; saw_low = 0;
        in_sub = 1'b0;
        in_cin = 1'b0;
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("b2b_c%0d_valid", c), out_valid, m_v2);
            if (m_v2 && rcv < 4) begin
                chk($sformatf("b2b_c%0d_sum", c), out_sum, bb_sum[rcv]);
                chk($sformatf("b2b_c%0d_cout", c), out_cout, bb_cout[rcv]);
            end
            ordy      = !(c >= 3 && c <= 5);
            out_ready = ordy;
            in_valid  = (sent < 4);
            in_a      = (sent < 4) ? bb_a[sent] : 32'h0;
            in_b      = (sent < 4) ? bb_b[sent] : 32'h0;
            #1;
            exp_rdy = !m_v1 || !m_v2 || ordy;
            chk($sformatf("b2b_c%0d_in_ready", c), in_ready, exp_rdy);
            if (!in_ready) saw_low = 1;
            adv = m_v1 && (!m_v2 || ordy);
            acc = in_valid && exp_rdy;
            if (m_v2 && ordy) rcv++;
            m_v2 = adv ? 1'b1 : (ordy ? 1'b0 : m_v2);
            m_v1 = acc ? 1'b1 : (adv ? 1'b0 : m_v1);
            if (acc) sent++;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_received", rcv, 4);
        chk("b2b_in_ready_dropped", saw_low, 1);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h0000_0010;
        in_b      = 32'h0000_0020;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'h0000_0100;
        in_b = 32'h0000_0200;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_full_valid", out_valid, 1);
        chk("mid_full_in_ready", in_ready, 0);
        chk("mid_full_sum", out_sum, 32'h0000_0030);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_sum", out_sum, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("mid_post_c%0d_valid", c), out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
